umi_mem_arbiter: RTL and testbench
==================================

# umi_mem_arbiter

N-host request arbiter and response router that sits directly upstream of the memory agent's device port (`udev_req_*` / `udev_resp_*`). Merges N host UMI request streams into one registered request stream using round-robin arbitration with EOM-based transaction locking. Steers the agent's single response stream back to the originating host using a host-ID field in the response destination address.

## Interface
Parameters:
- `N`, 2: number of host ports (2..8).
- `DW`, 256: UMI data width.
- `AW`, 64: address width.
- `CW`, 32: command width.
- `IDLSB`, 40: LSB of the host-ID field in `srcaddr` (requests) and `dstaddr` (responses); field width is `$clog2(N)`.

Ports (host buses are flattened; host k occupies slice `[k*W +: W]`):
- `clk`, in, 1: clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `host_req_valid`, in, N: per-host request valid.
- `host_req_cmd`, in, N*CW: request command.
- `host_req_dstaddr`, in, N*AW: request destination address.
- `host_req_srcaddr`, in, N*AW: request source address.
- `host_req_data`, in, N*DW: request data.
- `host_req_ready`, out, N: per-host request ready.
- `udev_req_valid` / `_cmd` / `_dstaddr` / `_srcaddr` / `_data`, out, 1/CW/AW/AW/DW: merged request to the memory agent.
- `udev_req_ready`, in, 1: memory agent accepts request.
- `udev_resp_valid` / `_cmd` / `_dstaddr` / `_srcaddr` / `_data`, in, 1/CW/AW/AW/DW: response from the memory agent.
- `udev_resp_ready`, out, 1: response accepted.
- `host_resp_valid`, out, N: per-host response valid.
- `host_resp_cmd` / `_dstaddr` / `_srcaddr` / `_data`, out, N*CW/N*AW/N*AW/N*DW: response fields, broadcast to all hosts.
- `host_resp_ready`, in, N: per-host response ready.
- `err_route`, out, 1: sticky flag for an unroutable response.

## Operation
- **Output register.** A one-entry request register (`udev_req_*`) loads when `load = ~udev_req_valid | udev_req_ready`.
- **Arbitration.**
  - While unlocked, the block grants the first requesting host at or after `rr_ptr`, searching in increasing index order with wrap.
  - `host_req_ready[k] = load & grant[k]`. At most one host is ready per cycle.
  - On each accepted packet (`host_req_valid[g] & host_req_ready[g]`), the register captures that host's fields unchanged.
- **Locking.**
  - If an accepted packet has `cmd[22]` (EOM) = 0, the arbiter locks to host g. Grant stays at g until a packet with EOM=1 from g is accepted.
  - While locked, other hosts' `host_req_ready` is 0 even when g is idle.
  - On acceptance of an EOM=1 packet, the lock clears and `rr_ptr` becomes (g+1) mod N.
- **Arbitration state machine.**
  - IDLE: no lock. Goes to LOCK on acceptance with EOM=0.
  - LOCK (holds `lock_id`): goes to IDLE on acceptance with EOM=1 from `lock_id`.
- **Response routing.**
  - `id = udev_resp_dstaddr[IDLSB +: $clog2(N)]`.
  - If `id < N`: `host_resp_valid[id] = udev_resp_valid`, all other valids are 0, and `udev_resp_ready = host_resp_ready[id]`.
  - If `id >= N`: all host valids are 0, `udev_resp_ready = 1` (the response is dropped), and `err_route` is set.
  - `err_route` clears only on reset.
- **Ordering.** Request fields pass through unmodified; the block never alters `srcaddr`. Hosts must place their own ID in `srcaddr[IDLSB +: $clog2(N)]`.

## Timing
- **Reset values:**
  - `udev_req_valid` = 0; `udev_req_*` fields = 0.
  - `host_req_ready` = 0 while `reset` is high.
  - `rr_ptr` = 0; state = IDLE; `err_route` = 0.
  - Response outputs are combinational from inputs.
- **Request latency.** A packet accepted in cycle t appears on `udev_req_*` in cycle t+1. Full throughput: one packet per cycle while `udev_req_ready` = 1.
- **Backpressure.** `udev_req_*` is held stable while `udev_req_valid & ~udev_req_ready`.
- **Response path.** Zero latency (combinational); no response buffering.
- **Simultaneous requests.** With all hosts valid, unlocked, and `rr_ptr=0`, grant order is 0, 1, ..., N-1, 0.
- **Pointer wrap.** Acceptance by host N-1 sets `rr_ptr` to 0.
- **Lock host drops valid.** If the locked host deasserts valid mid-transaction, no other host is served and no bubble-filling occurs.
- **Reset mid-transaction.** The lock is lost, the register empties, and the partially sent transaction is abandoned. Hosts are responsible for recovery.
- **Request/response independence.** Request acceptance and response delivery in the same cycle do not interact.

## Test plan
- **Single host.** N=2; host0 sends 4 EOM=1 writes back-to-back with `udev_req_ready`=1 → 4 packets on `udev_req_*` in cycles 1–4, data unchanged, `host_req_ready[1]` never set.
- **Round robin.** Both hosts are continuously valid with EOM=1 → `udev_req_srcaddr` host IDs alternate 0, 1, 0, 1 starting from host 0 after reset.
- **Lock.** Host1 sends 3 packets with EOM=0, 0, 1 while host0 is valid throughout → the 3 host1 packets are contiguous on the output, and host0 is granted in the next accepted cycle.
- **Backpressure.** `udev_req_ready`=0 for 5 cycles with a packet held in the register → output stable, all `host_req_ready`=0. On release, the next packet follows 1 cycle later with no loss or duplication.
- **Response routing.** A response with dstaddr ID=1 and `host_resp_ready[1]`=0 for 3 cycles → `host_resp_valid`=2'b10 and `udev_resp_ready`=0 until ready rises.
- **Bad route.** N=3; a response with ID=3 → all host valids 0, `udev_resp_ready`=1, `err_route`=1 from the next cycle. It remains 1 until `reset` is asserted.

Source files
------------

// File: rtl/umi_mem_arbiter.sv
// umi_mem_arbiter: round-robin UMI request merge with EOM transaction locking and ID-based response routing
module umi_mem_arbiter #(
  parameter int N     = 2,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int IDLSB = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    host_req_valid,
  input  logic [N*CW-1:0] host_req_cmd,
  input  logic [N*AW-1:0] host_req_dstaddr,
  input  logic [N*AW-1:0] host_req_srcaddr,
  input  logic [N*DW-1:0] host_req_data,
  output logic [N-1:0]    host_req_ready,
  output logic            udev_req_valid,
  output logic [CW-1:0]   udev_req_cmd,
  output logic [AW-1:0]   udev_req_dstaddr,
  output logic [AW-1:0]   udev_req_srcaddr,
  output logic [DW-1:0]   udev_req_data,
  input  logic            udev_req_ready,
  input  logic            udev_resp_valid,
  input  logic [CW-1:0]   udev_resp_cmd,
  input  logic [AW-1:0]   udev_resp_dstaddr,
  input  logic [AW-1:0]   udev_resp_srcaddr,
  input  logic [DW-1:0]   udev_resp_data,
  output logic            udev_resp_ready,
  output logic [N-1:0]    host_resp_valid,
  output logic [N*CW-1:0] host_resp_cmd,
  output logic [N*AW-1:0] host_resp_dstaddr,
  output logic [N*AW-1:0] host_resp_srcaddr,
  output logic [N*DW-1:0] host_resp_data,
  input  logic [N-1:0]    host_resp_ready,
  output logic            err_route
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t        r_state;
  logic [IW-1:0] r_rr_ptr, r_lock_id, w_gid, w_rid, w_ptr_nxt;
  logic          r_valid, r_err, w_found, w_load, w_acc;
  logic [CW-1:0] r_cmd, w_cmd;
  logic [AW-1:0] r_dst, r_src;
  logic [DW-1:0] r_data;
  logic [N-1:0]  w_hit;
  // Later assignments win: lowest requester at/after the pointer, else lowest below it.
  always_comb begin
    w_found = 1'b0;
    w_gid = r_rr_ptr;
    for (int k = N - 1; k >= 0; k--)
      if (host_req_valid[k] && IW'(k) < r_rr_ptr) begin
        w_found = 1'b1;
        w_gid = IW'(k);
      end
    for (int k = N - 1; k >= 0; k--)
      if (host_req_valid[k] && IW'(k) >= r_rr_ptr) begin
        w_found = 1'b1;
        w_gid = IW'(k);
      end
    if (r_state == LOCK) begin
      w_found = 1'b1;
      w_gid = r_lock_id;
    end
  end
  assign w_load         = ~r_valid | udev_req_ready;
  assign host_req_ready = (w_load & ~reset & w_found) ? ({{(N-1){1'b0}}, 1'b1} << w_gid) : '0;
  assign w_acc          = |(host_req_valid & host_req_ready);
  assign w_cmd          = host_req_cmd[w_gid*CW +: CW];
  assign w_ptr_nxt      = (w_gid == IW'(N - 1)) ? '0 : w_gid + 1'b1;
  always_ff @(posedge clk)
    if (reset) begin
      r_valid   <= 1'b0;
      r_cmd     <= '0;
      r_dst     <= '0;
      r_src     <= '0;
      r_data    <= '0;
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_load) r_valid <= w_acc;
      if (w_acc) begin
        r_cmd     <= w_cmd;
        r_dst     <= host_req_dstaddr[w_gid*AW +: AW];
        r_src     <= host_req_srcaddr[w_gid*AW +: AW];
        r_data    <= host_req_data[w_gid*DW +: DW];
        r_state   <= w_cmd[22] ? IDLE : LOCK;
        r_lock_id <= w_gid;
        if (w_cmd[22]) r_rr_ptr <= w_ptr_nxt;
      end
      if (udev_resp_valid && !(|w_hit)) r_err <= 1'b1;
    end
  assign udev_req_valid   = r_valid;
  assign udev_req_cmd     = r_cmd;
  assign udev_req_dstaddr = r_dst;
  assign udev_req_srcaddr = r_src;
  assign udev_req_data    = r_data;
  assign err_route        = r_err;
  // An ID with no matching host is swallowed so the agent never stalls on it.
  assign w_rid = udev_resp_dstaddr[IDLSB +: IW];
  always_comb begin
    udev_resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      w_hit[k] = (w_rid == IW'(k));
      if (w_hit[k]) udev_resp_ready = host_resp_ready[k];
    end
  end
  assign host_resp_valid   = udev_resp_valid ? w_hit : '0;
  assign host_resp_cmd     = {N{udev_resp_cmd}};
  assign host_resp_dstaddr = {N{udev_resp_dstaddr}};
  assign host_resp_srcaddr = {N{udev_resp_srcaddr}};
  assign host_resp_data    = {N{udev_resp_data}};
endmodule

// File: tb/tb_umi_mem_arbiter.sv
// tb_umi_mem_arbiter: directed stimulus, per-cycle compare against a behavioural model, literal sequence checks
module tb_umi_mem_arbiter;
  localparam int N = 3, DW = 16, AW = 64, CW = 32, IDL = 40;
  logic            clk = 0, reset = 1;
  logic [N-1:0]    host_req_valid = '0, host_req_ready;
  logic [N*CW-1:0] host_req_cmd = '0;
  logic [N*AW-1:0] host_req_dstaddr = '0, host_req_srcaddr = '0;
  logic [N*DW-1:0] host_req_data = '0;
  logic            udev_req_valid, udev_req_ready = 1;
  logic [CW-1:0]   udev_req_cmd;
  logic [AW-1:0]   udev_req_dstaddr, udev_req_srcaddr;
  logic [DW-1:0]   udev_req_data;
  logic            udev_resp_valid = 0, udev_resp_ready;
  logic [CW-1:0]   udev_resp_cmd = '0;
  logic [AW-1:0]   udev_resp_dstaddr = '0, udev_resp_srcaddr = '0;
  logic [DW-1:0]   udev_resp_data = '0;
  logic [N-1:0]    host_resp_valid, host_resp_ready = '0;
  logic [N*CW-1:0] host_resp_cmd;
  logic [N*AW-1:0] host_resp_dstaddr, host_resp_srcaddr;
  logic [N*DW-1:0] host_resp_data;
  logic            err_route;
  umi_mem_arbiter #(.N(N), .DW(DW), .AW(AW), .CW(CW), .IDLSB(IDL)) dut (
    .clk(clk), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_cmd(host_req_cmd),
    .host_req_dstaddr(host_req_dstaddr), .host_req_srcaddr(host_req_srcaddr),
    .host_req_data(host_req_data), .host_req_ready(host_req_ready),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .host_resp_valid(host_resp_valid), .host_resp_cmd(host_resp_cmd),
    .host_resp_dstaddr(host_resp_dstaddr), .host_resp_srcaddr(host_resp_srcaddr),
    .host_resp_data(host_resp_data), .host_resp_ready(host_resp_ready),
    .err_route(err_route)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  bit go = 0;
  int pk_idx[N], pk_cnt[N];
  bit hold[N];
  bit eom_seq[N][64];
  int seen_h[$], seen_d[$];
  bit          m_vld = 0, m_err = 0;
  logic [31:0] m_cmd = '0;
  logic [63:0] m_dst = '0, m_src = '0;
  logic [15:0] m_data = '0;
  int          m_lock = -1, m_ptr = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask
  // Host with the lock keeps priority; otherwise first valid host scanning up from the pointer.
  function automatic int mgrant();
    if (m_lock >= 0) return m_lock;
    for (int i = 0; i < N; i++)
      if (host_req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction
  function automatic int rid();
    return int'(udev_resp_dstaddr[IDL +: 2]);
  endfunction
  function automatic logic [63:0] pack(input bit d);
    logic [63:0] v = 64'hF;
    for (int i = 0; i < seen_h.size(); i++) v = (v << 4) | 64'(d ? (seen_d[i] & 15) : seen_h[i]);
    return v;
  endfunction
  task automatic chk_seq(input string nm, input logic [63:0] eh, input logic [63:0] ed);
    chk({nm, "_ids"}, pack(0), eh);
    chk({nm, "_data"}, pack(1), ed);
    seen_h.delete();
    seen_d.delete();
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      host_req_valid[k] = !hold[k] && pk_idx[k] < pk_cnt[k];
      host_req_cmd[k*CW +: CW]     = (32'(eom_seq[k][pk_idx[k] % 64]) << 22) | 32'(pk_idx[k]);
      host_req_srcaddr[k*AW +: AW] = (64'(k) << IDL) | 64'(pk_idx[k]);
      host_req_dstaddr[k*AW +: AW] = 64'h1000 + 64'(k * 256 + pk_idx[k]);
      host_req_data[k*DW +: DW]    = 16'(k * 4096 + pk_idx[k]);
    end
  endtask
  task automatic tick(input int n);
    logic [N-1:0] acc;
    repeat (n) begin
      @(negedge clk);
      acc = host_req_valid & host_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) pk_idx[k]++;
      drive();
    end
  endtask
  always @(posedge clk) begin
    int g;
    bit ld, acc;
    g   = mgrant();
    ld  = !m_vld || udev_req_ready;
    acc = ld && g >= 0 && host_req_valid[g < 0 ? 0 : g];
    if (reset) begin
      m_vld <= 0; m_cmd <= '0; m_dst <= '0; m_src <= '0; m_data <= '0;
      m_lock <= -1; m_ptr <= 0; m_err <= 0;
    end else begin
      if (ld) m_vld <= acc;
      if (acc) begin
        m_cmd  <= host_req_cmd[g*CW +: CW];
        m_dst  <= host_req_dstaddr[g*AW +: AW];
        m_src  <= host_req_srcaddr[g*AW +: AW];
        m_data <= host_req_data[g*DW +: DW];
        if (!host_req_cmd[g*CW + 22]) m_lock <= g;
        else begin
          m_lock <= -1;
          m_ptr  <= (g + 1) % N;
        end
      end
      if (udev_resp_valid && rid() >= N) m_err <= 1;
    end
  end
  always @(negedge clk) if (go) begin
    int g, id;
    bit ld;
    logic [N-1:0] er, ev;
    logic eu;
    g  = mgrant();
    ld = !m_vld || udev_req_ready;
    er = (!reset && ld && g >= 0) ? (N'(1) << g) : '0;
    id = rid();
    ev = '0;
    eu = 1;
    if (id < N) begin
      ev = udev_resp_valid ? (N'(1) << id) : '0;
      eu = host_resp_ready[id];
    end
    chk("host_req_ready", 64'(host_req_ready), 64'(er));
    chk("udev_req_valid", 64'(udev_req_valid), 64'(m_vld));
    chk("udev_req_cmd", 64'(udev_req_cmd), 64'(m_cmd));
    chk("udev_req_dstaddr", udev_req_dstaddr, m_dst);
    chk("udev_req_srcaddr", udev_req_srcaddr, m_src);
    chk("udev_req_data", 64'(udev_req_data), 64'(m_data));
    chk("host_resp_valid", 64'(host_resp_valid), 64'(ev));
    chk("udev_resp_ready", 64'(udev_resp_ready), 64'(eu));
    chk("err_route", 64'(err_route), 64'(m_err));
    chk("host_resp_data_bc", 64'(host_resp_data[2*DW +: DW]), 64'(udev_resp_data));
    if (udev_req_valid && udev_req_ready) begin
      seen_h.push_back(int'(udev_req_srcaddr[IDL +: 2]));
      seen_d.push_back(int'(udev_req_data));
    end
  end
  initial begin
    for (int k = 0; k < N; k++) begin
      pk_idx[k] = 0;
      pk_cnt[k] = 0;
      hold[k] = 0;
      for (int i = 0; i < 64; i++) eom_seq[k][i] = 1;
    end
    drive();
    tick(2);
    go = 1;
    pk_cnt[0] = 4;
    drive();
    #1;
    chk("reset_ready", 64'(host_req_ready), 64'h0);
    chk("reset_udev_valid", 64'(udev_req_valid), 64'h0);
    tick(1);
    reset = 0;
    tick(6);
    chk_seq("single", 64'hF0000, 64'hF0123);
    reset = 1;
    tick(1);
    reset = 0;
    pk_cnt[0] += 3;
    pk_cnt[1] += 3;
    drive();
    tick(8);
    chk_seq("rr", 64'hF010101, 64'hF405162);
    pk_cnt[0] += 1;
    pk_cnt[2] += 1;
    drive();
    tick(4);
    chk_seq("wrap", 64'hF20, 64'hF07);
    eom_seq[1][3] = 0;
    eom_seq[1][4] = 0;
    pk_cnt[1] += 3;
    pk_cnt[0] += 3;
    drive();
    tick(1);
    hold[1] = 1;
    drive();
    tick(2);
    hold[1] = 0;
    drive();
    tick(8);
    chk_seq("lock", 64'hF111000, 64'hF34589A);
    pk_cnt[0] += 3;
    drive();
    tick(1);
    udev_req_ready = 0;
    tick(5);
    chk("bp_stall_ready", 64'(host_req_ready), 64'h0);
    chk("bp_stall_data", 64'(udev_req_data), 64'hB);
    udev_req_ready = 1;
    tick(5);
    chk_seq("bp", 64'hF000, 64'hFBCD);
    eom_seq[1][6] = 0;
    pk_cnt[1] += 1;
    drive();
    tick(1);
    reset = 1;
    tick(1);
    reset = 0;
    pk_cnt[0] += 1;
    drive();
    tick(3);
    chk_seq("rst_mid", 64'hF10, 64'hF6E);
    pk_cnt[2] += 2;
    drive();
    udev_resp_valid   = 1;
    udev_resp_dstaddr = 64'h0000_0100_0000_0000;
    udev_resp_data    = 16'hBEEF;
    udev_resp_cmd     = 32'h5;
    host_resp_ready   = 3'b000;
    #1;
    chk("route_valid", 64'(host_resp_valid), 64'h2);
    chk("route_ready_lo", 64'(udev_resp_ready), 64'h0);
    tick(3);
    chk("route_hold", 64'(udev_resp_ready), 64'h0);
    host_resp_ready = 3'b010;
    #1;
    chk("route_ready_hi", 64'(udev_resp_ready), 64'h1);
    chk("route_bcast", 64'(host_resp_data[0 +: DW]), 64'hBEEF);
    tick(1);
    udev_resp_valid   = 1;
    udev_resp_dstaddr = 64'h0000_0300_0000_0000;
    host_resp_ready   = 3'b000;
    #1;
    chk("bad_valid", 64'(host_resp_valid), 64'h0);
    chk("bad_ready", 64'(udev_resp_ready), 64'h1);
    chk("bad_err_before", 64'(err_route), 64'h0);
    tick(1);
    chk("bad_err_set", 64'(err_route), 64'h1);
    udev_resp_valid   = 0;
    udev_resp_dstaddr = '0;
    tick(3);
    chk("bad_err_sticky", 64'(err_route), 64'h1);
    reset = 1;
    tick(1);
    chk("bad_err_reset", 64'(err_route), 64'h0);
    reset = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
